// File: rtl/life_matrix_scan.sv
// Row-scanned LED matrix driver with a double-buffered frame, a blank
// interval before each row, per-row PWM and a swap handshake.

module life_matrix_row #(
  parameter int X = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         sel,
  input  logic [X-1:0] d,
  output logic [X-1:0] q0,
  output logic [X-1:0] q1
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q0 <= '0;
      q1 <= '0;
    end else if (we) begin
      if (sel) q1 <= d;
      else     q0 <= d;
    end
  end
endmodule

module life_matrix_scan #(
  parameter int X              = 8,
  parameter int Y              = 8,
  parameter int LOG2Y          = 3,
  parameter int DWELL_W        = 4,
  parameter int DWELL          = 8,
  parameter int BLANK          = 2,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [LOG2Y-1:0]   wr_addr,
  input  logic [X-1:0]       wr_data,
  input  logic               swap_req,
  input  logic [DWELL_W-1:0] bright,
  output logic               swap_ack,
  output logic               frame_start,
  output logic [LOG2Y-1:0]   cur_row,
  output logic [Y-1:0]       row,
  output logic [X-1:0]       col
);
  localparam int BW    = $clog2(BLANK + 1);
  localparam int CNT_W = (DWELL_W > BW) ? DWELL_W : BW;

  typedef enum logic {S_BLANK, S_ON} phase_t;

  // phase/cnt/rix describe the cycle currently on the pins; run = 0 means
  // the first post-reset cycle has not been shown yet, so position 0 is held
  phase_t             phase, n_phase;
  logic [CNT_W-1:0]   cnt, n_cnt;
  logic [LOG2Y-1:0]   rix, n_rix;
  logic               run;
  logic               front;
  logic               pending;
  logic [DWELL_W-1:0] bright_l, bright_n;
  logic               wrap, do_swap, on, lit;
  logic [Y-1:0]       oh;
  logic [X-1:0]       frow;
  logic               wr_hit;

  logic [Y-1:0][X-1:0] buf0, buf1;

  assign wr_hit = wr_en && ({1'b0, wr_addr} < (LOG2Y+1)'(Y));

  for (genvar r = 0; r < Y; r++) begin : g_row
    life_matrix_row #(.X(X)) u_row (
      .clk (clk),
      .rst (rst),
      .we  (wr_hit && (wr_addr == LOG2Y'(r))),
      .sel (~front),
      .d   (wr_data),
      .q0  (buf0[r]),
      .q1  (buf1[r])
    );
  end

  always_comb begin
    n_phase = phase;
    n_cnt   = cnt;
    n_rix   = rix;
    wrap    = 1'b0;
    if (run) begin
      if (phase == S_BLANK) begin
        if (cnt == CNT_W'(BLANK - 1)) begin
          n_phase = S_ON;
          n_cnt   = '0;
        end else begin
          n_cnt = cnt + CNT_W'(1);
        end
      end else begin
        if (cnt == CNT_W'(DWELL - 1)) begin
          n_phase = S_BLANK;
          n_cnt   = '0;
          if (rix == LOG2Y'(Y - 1)) begin
            n_rix = '0;
            wrap  = 1'b1;
          end else begin
            n_rix = rix + LOG2Y'(1);
          end
        end else begin
          n_cnt = cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    do_swap  = wrap && (pending || swap_req);
    on       = (n_phase == S_ON);
    // brightness for a row is taken on entry to its ON phase
    bright_n = (phase == S_BLANK && on) ? bright : bright_l;
    lit      = on && (n_cnt < CNT_W'(bright_n));
    frow     = front ? buf1[n_rix] : buf0[n_rix];
    oh       = '0;
    if (on) oh[n_rix] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= S_BLANK;
      cnt         <= '0;
      rix         <= '0;
      run         <= 1'b0;
      front       <= 1'b0;
      pending     <= 1'b0;
      bright_l    <= '0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      row         <= {Y{ROW_ACTIVE_LOW}};
      col         <= {X{COL_ACTIVE_LOW}};
    end else begin
      run         <= 1'b1;
      phase       <= n_phase;
      cnt         <= n_cnt;
      rix         <= n_rix;
      bright_l    <= bright_n;
      pending     <= do_swap ? 1'b0 : (pending | swap_req);
      if (do_swap) front <= ~front;
      swap_ack    <= do_swap;
      frame_start <= ~run | wrap;
      row         <= oh ^ {Y{ROW_ACTIVE_LOW}};
      col         <= (lit ? frow : '0) ^ {X{COL_ACTIVE_LOW}};
    end
  end

  assign cur_row = rix;
endmodule

// File: tb/tb_life_matrix_scan.sv
// Self-checking bench: position-arithmetic frame model checked every cycle
// against an active-high and an active-low instance, plus pinned literals.

module tb_life_matrix_scan;
  localparam int X = 8, Y = 8, BLANK = 2, DWELL = 8;
  localparam int P = BLANK + DWELL, FR = Y * P;

  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, swap_req = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] bright = 4'd15;

  logic       ack0, fs0, ack1, fs1;
  logic [2:0] cr0, cr1;
  logic [7:0] row0, col0, row1, col1;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  life_matrix_scan dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .bright(bright), .swap_ack(ack0), .frame_start(fs0),
    .cur_row(cr0), .row(row0), .col(col0));

  life_matrix_scan #(.ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .bright(bright), .swap_ack(ack1), .frame_start(fs1),
    .cur_row(cr1), .row(row1), .col(col1));

  // model: cycle t since reset release decides row/phase by plain arithmetic
  int         t = -1, pos, r, k, brl;
  logic [7:0] mem [2][8];
  bit         front, pend, sw;
  logic [7:0] e_row, e_col;
  logic [2:0] e_cr;
  logic       e_fs, e_ack;

  always @(posedge clk) begin
    if (rst) begin
      t = -1; front = 0; pend = 0; brl = 0;
      for (int i = 0; i < 8; i++) begin mem[0][i] = 0; mem[1][i] = 0; end
      e_row = 0; e_col = 0; e_cr = 0; e_fs = 0; e_ack = 0;
    end else begin
      t++;
      pos = t % FR; r = pos / P; k = pos % P;
      sw = (pos == 0) && (t > 0) && (pend || swap_req);
      if (wr_en && int'(wr_addr) < Y) mem[front ? 0 : 1][wr_addr] = wr_data;
      pend = sw ? 0 : (pend | swap_req);
      if (sw) front = !front;
      if (k == BLANK) brl = int'(bright);
      e_fs  = (pos == 0);
      e_ack = sw;
      e_cr  = 3'(r);
      e_row = (k >= BLANK) ? 8'(1 << r) : 8'h00;
      e_col = (k >= BLANK && (k - BLANK) < brl && (k - BLANK) < DWELL)
              ? mem[front ? 1 : 0][r] : 8'h00;
    end
  end

  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, a, e);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("row",     row0,       e_row);
    chk("col",     col0,       e_col);
    chk("cur_row", 8'(cr0),    8'(e_cr));
    chk("fs",      8'(fs0),    8'(e_fs));
    chk("ack",     8'(ack0),   8'(e_ack));
    chk("row_n",   row1,       ~e_row);
    chk("col_n",   col1,       ~e_col);
    chk("cur_row_n", 8'(cr1),  8'(e_cr));
    chk("fs_n",    8'(fs1),    8'(e_fs));
    chk("ack_n",   8'(ack1),   8'(e_ack));
  end

  task automatic at_cyc(input int n);
    int g = 0;
    while (t != n && g < 5000) begin @(posedge clk); #1; g++; end
    if (t != n) begin
      total++; bad++;
      $display("FAIL wait_cycle t=%0d want=%0d", t, n);
    end
  endtask

  task automatic release_rst();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    release_rst();
    chk_en = 1'b1;

    at_cyc(0);
    chk("lit_fs0", 8'(fs0), 8'h01);
    chk("lit_row0", row0, 8'h00);
    chk("lit_col0", col0, 8'h00);
    chk("lit_row_n0", row1, 8'hFF);
    chk("lit_col_n0", col1, 8'hFF);
    at_cyc(2);  chk("lit_row_c2", row0, 8'h01);
    at_cyc(3);  wr_en = 1; wr_addr = 3; wr_data = 8'hA5;
    at_cyc(4);  wr_en = 0;
    at_cyc(5);  swap_req = 1;
    at_cyc(6);  swap_req = 0;
    at_cyc(10); chk("lit_row_c10", row0, 8'h00);
    at_cyc(12); chk("lit_row_c12", row0, 8'h02);
    at_cyc(20); swap_req = 1;
    at_cyc(21); swap_req = 0;
    at_cyc(40); swap_req = 1;
    at_cyc(41); swap_req = 0;
    at_cyc(80);
    chk("lit_ack80", 8'(ack0), 8'h01);
    chk("lit_fs80", 8'(fs0), 8'h01);
    at_cyc(81); chk("lit_ack81", 8'(ack0), 8'h00);
    at_cyc(100); bright = 3;
    at_cyc(112);
    chk("lit_row112", row0, 8'h08);
    chk("lit_col112", col0, 8'hA5);
    chk("lit_row_n112", row1, 8'hF7);
    chk("lit_col_n112", col1, 8'h5A);
    at_cyc(113); bright = 8;
    at_cyc(114); chk("lit_col114", col0, 8'hA5);
    at_cyc(115); chk("lit_col115", col0, 8'h00);
    at_cyc(122); bright = 15; chk("lit_col122_row4", col0, 8'h00);
    at_cyc(160); chk("lit_ack160", 8'(ack0), 8'h00);
    at_cyc(239); swap_req = 1;
    at_cyc(240);
    swap_req = 0;
    chk("lit_ack240", 8'(ack0), 8'h01);
    chk("lit_fs240", 8'(fs0), 8'h01);

    for (int i = 0; i < 1600; i++) begin
      @(posedge clk); #1;
      wr_en    = 1'($urandom % 2);
      wr_addr  = 3'($urandom % 8);
      wr_data  = 8'($urandom);
      swap_req = ($urandom % 40) == 0;
      bright   = ($urandom % 4 == 0) ? 4'd15 : 4'($urandom % 16);
    end
    wr_en = 0; swap_req = 0; bright = 15;

    @(posedge clk); #1 rst = 1'b1;
    release_rst();
    at_cyc(20); swap_req = 1;
    at_cyc(21); swap_req = 0;
    at_cyc(115); rst = 1'b1;
    @(posedge clk); #1;
    chk("lit_rst_row", row0, 8'h00);
    chk("lit_rst_col", col0, 8'h00);
    chk("lit_rst_ack", 8'(ack0), 8'h00);
    chk("lit_rst_row_n", row1, 8'hFF);
    chk("lit_rst_col_n", col1, 8'hFF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    at_cyc(0);  chk("lit_rst_fs0", 8'(fs0), 8'h01);
    at_cyc(32); chk("lit_rst_row3", row0, 8'h08);
    at_cyc(80);
    chk("lit_rst_fs80", 8'(fs0), 8'h01);
    chk("lit_rst_ack80", 8'(ack0), 8'h00);
    at_cyc(90);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/life_matrix_scan.md
# life_matrix_scan

Parametrised LED-matrix scan driver for the life display path: holds a double-buffered X×Y frame, scans it one row at a time with a programmable dwell and anti-ghosting blank interval, and applies per-row PWM brightness and selectable output polarity. It sits between the life-engine row writer and the matrix pins. It replaces the fixed 8×8 display stage with a free-running internal scan counter and a frame swap handshake.

## Interface
- X, 8: columns per row (col width, frame row width)
- Y, 8: rows (row width, buffer depth)
- LOG2Y, 3: width of row index; 2^LOG2Y ≥ Y
- DWELL_W, 4: width of dwell counter and `bright`
- DWELL, 8: ON cycles per row, 1..2^DWELL_W-1
- BLANK, 2: blank cycles before each row's ON phase, ≥1
- ROW_ACTIVE_LOW, 0: 1 = row outputs active-low
- COL_ACTIVE_LOW, 0: 1 = col outputs active-low
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write one row into back buffer
- wr_addr  in  LOG2Y  row index; values ≥ Y ignored
- wr_data  in  X  row bits, bit i = column i lit
- swap_req  in  1  pulse: request front/back swap at next frame boundary
- bright  in  DWELL_W  lit cycles per row ON phase; ≥ DWELL = full on
- swap_ack  out  1  one-cycle pulse when swap takes effect
- frame_start  out  1  one-cycle pulse at first cycle of row 0
- cur_row  out  LOG2Y  row currently being scanned
- row  out  Y  row drive, one-hot active during ON phase
- col  out  X  column drive

## Operation
- Storage: two Y×X flop buffers; `front` bit selects displayed buffer. Writes always target the non-front buffer as of that cycle.
- FSM: BLANK (count BLANK cycles) → ON (count DWELL cycles) → BLANK of next row. Row index wraps Y-1 → 0.
- BLANK: row and col all inactive; cur_row = upcoming row.
- ON: row bit cur_row active, others inactive; col bit i active iff front[cur_row][i]=1 and dwell_cnt < bright_l.
- bright_l latched from `bright` on the BLANK→ON transition; changes mid-row do not affect the current row.
- swap_req sets pending; repeat requests while pending are absorbed (one swap). At the ON→BLANK transition of row Y-1 with pending set: toggle front, clear pending, assert swap_ack in the following cycle together with frame_start.
- Write in the same cycle as the swap toggle lands in the pre-swap back buffer, i.e. it becomes visible immediately as front.
- Polarity: inactive level is 1 when *_ACTIVE_LOW = 1, else 0; applied to every row/col bit, including reset values.
- rst: FSM → BLANK of row 0, counters 0, front = 0, pending = 0, both buffers cleared, bright_l = 0; row/col inactive, swap_ack = 0, cur_row = 0, frame_start = 0. Reset mid-frame or mid-swap discards pending request.

## Timing
- All outputs registered. Cycle 0 = first cycle with rst low.
- frame_start = 1 in cycle 0 and every Y·(BLANK+DWELL) cycles after.
- Row r: blank in cycles r·P .. r·P+BLANK-1, ON in r·P+BLANK .. (r+1)·P-1, with P = BLANK+DWELL.
- ON phase: col lit for first min(bright_l, DWELL) cycles of the row, dark for the rest; bright_l = 0 → row driven, col dark.
- Write-to-display latency: back-buffer data visible at the first frame_start after an accepted swap; swap_req arriving in the last ON cycle of row Y-1 takes effect at that same boundary.
- swap_ack and frame_start coincide; swap_ack never occurs without frame_start.

## Test plan
- Reset, X=Y=8, BLANK=2, DWELL=8, bright=15: row=0x00, col=0x00 in cycle 0; row=0x01 in cycles 2–9, row=0x02 in 12–19; frame_start at 0 and 80.
- Write wr_addr=3 data 0xA5, swap_req at cycle 5: swap_ack+frame_start at cycle 80; in cycles 112–119 row=0x08, col=0xA5; other rows col=0x00.
- bright=3 latched for row 3: col=0xA5 for cycles 112–114, 0x00 for 115–119; bright changed to 8 at cycle 113 does not alter row 3.
- swap_req pulsed three times within one frame: exactly one swap_ack; front toggles once; request in cycle 79 swaps at cycle 80.
- ROW_ACTIVE_LOW=1, COL_ACTIVE_LOW=1: during reset and blank row=0xFF, col=0xFF; row 3 ON gives row=0xF7, col=0x5A.
- rst asserted mid-frame (cycle 115) with swap pending: next cycle outputs inactive, buffers zero, no swap_ack; scan restarts at row 0 with frame_start in the first cycle after rst drops.
